// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control unit for a multi-cycle RV32I core. A single FSM steps each
//   instruction through FETCH/DECODE/EXEC/MEM/WB over a shared datapath and
//   memory port. It waits on a memory ready handshake with a bounded timeout
//   and traps permanently on illegal encodings or memory timeouts.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   instr               instruction register (valid from DECODE onward)
//   mem_ready           memory access completes this cycle
//   brEq, brLt          datapath comparator results
//   br_unsigned         comparator mode (instr[13])
//   pc_write, pc_src    PC load enable and source (0 PC+4, 1 ALU)
//   ir_write            latch fetched word into IR / old_pc
//   mem_read, mem_write memory request strobes
//   iord                memory address select (0 PC, 1 ALU)
//   reg_write           register file write enable
//   alu_src_a/b, alu_op ALU operand selects and operation
//   imm_sel             immediate format (I/S/B/J/U)
//   result_src          write-back source (ALU, memory, old_pc+4)
//   state               current FSM state
//   illegal             sticky trap indicator
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5,
    parameter bit EN_JUMP     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        brEq,
    input  logic        brLt,
    output logic        br_unsigned,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [2:0]  imm_sel,
    output logic [1:0]  result_src,
    output logic [2:0]  state,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    state_t             state_r;
    logic [TMO_W-1:0]   cnt_r;
    logic               illegal_r;

    logic [6:0] opcode_s;
    logic [2:0] f3_s;
    logic [6:0] f7_s;
    logic       is_r_s, is_ialu_s, is_load_s, is_store_s, is_lui_s;
    logic       is_auipc_s, is_branch_s, is_jal_s, is_jalr_s;
    logic       bad_s;
    logic       taken_s;
    logic [3:0] alu_func_s;
    logic       unused_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_s = ^{instr[24:15], instr[11:7]};

    // Opcode classification and illegal-encoding detection.
    always_comb begin
        is_r_s      = 1'b0;
        is_ialu_s   = 1'b0;
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        is_lui_s    = 1'b0;
        is_auipc_s  = 1'b0;
        is_branch_s = 1'b0;
        is_jal_s    = 1'b0;
        is_jalr_s   = 1'b0;
        bad_s       = 1'b0;
        case (opcode_s)
            OP_R: begin
                is_r_s = 1'b1;
                if (f7_s == 7'h00) begin
                    bad_s = 1'b0;
                end else if (f7_s == 7'h20 && (f3_s == 3'b000 || f3_s == 3'b101)) begin
                    bad_s = 1'b0;
                end else begin
                    bad_s = 1'b1;
                end
            end
            OP_IALU: begin
                is_ialu_s = 1'b1;
                if (f3_s == 3'b001) begin
                    bad_s = (f7_s != 7'h00);
                end else if (f3_s == 3'b101) begin
                    bad_s = (f7_s != 7'h00) && (f7_s != 7'h20);
                end else begin
                    bad_s = 1'b0;
                end
            end
            OP_LOAD:   is_load_s  = 1'b1;
            OP_STORE:  is_store_s = 1'b1;
            OP_LUI:    is_lui_s   = 1'b1;
            OP_AUIPC: begin
                is_auipc_s = 1'b1;
                bad_s      = !EN_JUMP;
            end
            OP_BRANCH: begin
                is_branch_s = 1'b1;
                bad_s       = (f3_s == 3'b010) || (f3_s == 3'b011);
            end
            OP_JAL: begin
                is_jal_s = 1'b1;
                bad_s    = !EN_JUMP;
            end
            OP_JALR: begin
                is_jalr_s = 1'b1;
                bad_s     = !EN_JUMP || (f3_s != 3'b000);
            end
            default: bad_s = 1'b1;
        endcase
    end

    // Branch condition from funct3 and the datapath comparator.
    always_comb begin
        case (f3_s)
            3'b000:  taken_s = brEq;
            3'b001:  taken_s = !brEq;
            3'b100:  taken_s = brLt;
            3'b110:  taken_s = brLt;
            3'b101:  taken_s = !brLt;
            3'b111:  taken_s = !brLt;
            default: taken_s = 1'b0;
        endcase
    end

    // ALU operation for R and I-ALU; SUB is only reachable from R-type.
    always_comb begin
        case (f3_s)
            3'b000:  alu_func_s = (is_r_s && f7_s[5]) ? 4'b0001 : 4'b0000;
            3'b001:  alu_func_s = 4'b1001;
            3'b010:  alu_func_s = 4'b1101;
            3'b011:  alu_func_s = 4'b1110;
            3'b100:  alu_func_s = 4'b0110;
            3'b101:  alu_func_s = f7_s[5] ? 4'b1011 : 4'b1010;
            3'b110:  alu_func_s = 4'b0101;
            3'b111:  alu_func_s = 4'b0100;
            default: alu_func_s = 4'b0000;
        endcase
    end

    // Strobe decode from current state and instruction; rst forces all low.
    always_comb begin
        br_unsigned = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 4'b0000;
        imm_sel     = 3'b000;
        result_src  = 2'b00;
        if (rst) begin
            pc_write = 1'b0;
        end else begin
            // imm_sel follows the opcode for every post-fetch state.
            if (state_r == S_DECODE || state_r == S_EXEC || state_r == S_MEM || state_r == S_WB) begin
                if (is_store_s)       imm_sel = 3'b001;
                else if (is_branch_s) imm_sel = 3'b010;
                else if (is_jal_s)    imm_sel = 3'b011;
                else if (is_lui_s || is_auipc_s) imm_sel = 3'b100;
                else                  imm_sel = 3'b000;
                br_unsigned = instr[13];
            end else begin
                imm_sel = 3'b000;
            end
            case (state_r)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    if (is_r_s) begin
                        alu_op = alu_func_s;
                    end else if (is_ialu_s) begin
                        alu_src_b = 2'b01;
                        alu_op    = alu_func_s;
                    end else if (is_lui_s) begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                    end else if (is_auipc_s || is_jal_s) begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b01;
                        pc_write  = is_jal_s;
                        pc_src    = is_jal_s;
                    end else if (is_branch_s) begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b01;
                        pc_write  = taken_s;
                        pc_src    = taken_s;
                    end else if (is_jalr_s) begin
                        alu_src_b = 2'b01;
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                    end else begin
                        // LOAD/STORE address: rs1 + imm.
                        alu_src_b = 2'b01;
                    end
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = is_load_s;
                    mem_write = is_store_s;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (is_load_s)                    result_src = 2'b01;
                    else if (is_jal_s || is_jalr_s)   result_src = 2'b10;
                    else                              result_src = 2'b00;
                end
                default: pc_write = 1'b0;
            endcase
        end
    end

    // State sequencing, memory wait counter and sticky trap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FETCH;
            cnt_r     <= {TMO_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH, S_MEM: begin
                    // Ready wins even when the counter sits at the limit.
                    if (mem_ready) begin
                        cnt_r <= {TMO_W{1'b0}};
                        if (state_r == S_FETCH)  state_r <= S_DECODE;
                        else if (is_load_s)      state_r <= S_WB;
                        else                     state_r <= S_FETCH;
                    end else if (cnt_r == TMO_MAX) begin
                        state_r   <= S_TRAP;
                        illegal_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + TMO_W'(1);
                    end
                end
                S_DECODE: begin
                    cnt_r <= {TMO_W{1'b0}};
                    if (bad_s) begin
                        state_r   <= S_TRAP;
                        illegal_r <= 1'b1;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_r <= {TMO_W{1'b0}};
                    if (is_load_s || is_store_s) state_r <= S_MEM;
                    else if (is_branch_s)        state_r <= S_FETCH;
                    else                         state_r <= S_WB;
                end
                S_WB: begin
                    cnt_r   <= {TMO_W{1'b0}};
                    state_r <= S_FETCH;
                end
                S_TRAP: begin
                    state_r   <= S_TRAP;
                    illegal_r <= 1'b1;
                end
                default: begin
                    state_r   <= S_TRAP;
                    illegal_r <= 1'b1;
                end
            endcase
        end
    end

    assign state   = state_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready, brEq, brLt;
    logic        br_unsigned, pc_write, pc_src, ir_write, mem_read, mem_write;
    logic        iord, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_op;
    logic [2:0]  imm_sel, state;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .TMO_W(5), .EN_JUMP(1'b1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .brEq(brEq), .brLt(brLt), .br_unsigned(br_unsigned),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_sel(imm_sel), .result_src(result_src),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit later.
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; brEq = 1'b0; brLt = 1'b0;

        // Reset: two cycles, strobes forced low while rst is high.
        nxt;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        nxt;

        // ADD x3,x1,x2: F D E W
        rst = 1'b0; mem_ready = 1'b1; instr = 32'h002081B3; #1;
        chk("add_fetch_state", {29'd0, state}, 32'd0);
        chk("add_fetch_strb", {28'd0, mem_read, iord, ir_write, pc_write}, 32'b1011);
        chk("add_fetch_pcsrc", {31'd0, pc_src}, 32'd0);
        nxt;
        chk("add_dec_state", {29'd0, state}, 32'd1);
        chk("add_dec_rw", {31'd0, reg_write}, 32'd0);
        nxt;
        chk("add_exec_state", {29'd0, state}, 32'd2);
        chk("add_exec_alu", {24'd0, alu_op, alu_src_a, alu_src_b}, {24'd0, 4'b0000, 2'b00, 2'b00});
        chk("add_exec_rw", {31'd0, reg_write}, 32'd0);
        nxt;
        chk("add_wb_state", {29'd0, state}, 32'd4);
        chk("add_wb_rw", {29'd0, reg_write, result_src}, {29'd0, 1'b1, 2'b00});
        nxt;
        chk("add_done_state", {29'd0, state}, 32'd0);
        chk("add_done_rw", {31'd0, reg_write}, 32'd0);

        // LW x5,8(x1) with 3 wait cycles in MEM
        instr = 32'h0080A283; #1;
        nxt;
        chk("lw_dec_imm", {29'd0, imm_sel}, 32'd0);
        nxt;
        chk("lw_exec", {24'd0, alu_op, alu_src_a, alu_src_b}, {24'd0, 4'b0000, 2'b00, 2'b01});
        nxt;
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait", {29'd0, state, mem_read, iord} >> 0, {27'd0, 3'd3, 1'b1, 1'b1});
            nxt;
        end
        mem_ready = 1'b1; #1;
        chk("lw_mem_last", {27'd0, state, mem_read, iord}, {27'd0, 3'd3, 1'b1, 1'b1});
        chk("lw_mem_nowr", {31'd0, mem_write}, 32'd0);
        nxt;
        chk("lw_wb", {26'd0, state, reg_write, result_src}, {26'd0, 3'd4, 1'b1, 2'b01});
        nxt;
        chk("lw_done", {29'd0, state}, 32'd0);

        // BEQ taken: 3 cycles, PC loads ALU result in EXEC
        instr = 32'h00208463; brEq = 1'b1; #1;
        nxt;
        chk("beq_dec_imm", {29'd0, imm_sel}, 32'd2);
        nxt;
        chk("beq_t_exec", {28'd0, pc_write, pc_src, alu_src_a}, {28'd0, 1'b1, 1'b1, 2'b01});
        chk("beq_t_uns", {31'd0, br_unsigned}, 32'd0);
        nxt;
        chk("beq_t_done", {29'd0, state}, 32'd0);

        // BEQ not taken
        brEq = 1'b0; #1;
        nxt; nxt;
        chk("beq_nt_exec", {29'd0, state, pc_write}, {28'd0, 3'd2, 1'b0});
        nxt;
        chk("beq_nt_done", {29'd0, state}, 32'd0);

        // BLTU taken, unsigned compare mode
        instr = 32'h0020E463; brLt = 1'b1; #1;
        nxt; nxt;
        chk("bltu_exec", {29'd0, pc_write, pc_src, br_unsigned}, {29'd0, 3'b111});
        nxt;
        brLt = 1'b0;

        // SRAI x1,x1,1: ALU op from funct7 on an I-type
        instr = 32'h4010D093; #1;
        nxt; nxt;
        chk("srai_exec", {26'd0, alu_op, alu_src_b}, {26'd0, 4'b1011, 2'b01});
        nxt;
        chk("srai_wb", {29'd0, state}, 32'd4);
        nxt;

        // JAL x1,8: PC redirect in EXEC, writes old_pc+4
        instr = 32'h008000EF; #1;
        nxt;
        chk("jal_dec_imm", {29'd0, imm_sel}, 32'd3);
        nxt;
        chk("jal_exec", {28'd0, pc_write, pc_src, alu_src_a}, {28'd0, 1'b1, 1'b1, 2'b01});
        nxt;
        chk("jal_wb", {27'd0, state, result_src}, {27'd0, 3'd4, 2'b10});
        nxt;

        // SW fetch: ready arriving exactly when the counter hits the limit wins
        instr = 32'h0020A223; mem_ready = 1'b0; #1;
        for (int i = 0; i < 16; i++) nxt;
        chk("tmo_edge_state", {29'd0, state}, 32'd0);
        mem_ready = 1'b1; #1;
        chk("tmo_edge_irw", {31'd0, ir_write}, 32'd1);
        nxt;
        chk("tmo_edge_dec", {29'd0, state}, 32'd1);
        chk("sw_dec_imm", {29'd0, imm_sel}, 32'd1);
        nxt;
        // SW reset on the first MEM cycle
        mem_ready = 1'b0;
        nxt;
        chk("sw_mem_wr", {27'd0, state, mem_write, iord}, {27'd0, 3'd3, 1'b1, 1'b1});
        chk("sw_mem_rd", {31'd0, mem_read}, 32'd0);
        rst = 1'b1; #1;
        chk("sw_rst_wr", {31'd0, mem_write}, 32'd0);
        nxt;
        rst = 1'b0; #1;
        chk("sw_rst_state", {30'd0, state, mem_write} >> 0, {28'd0, 3'd0, 1'b0});

        // Illegal R-type XOR with funct7=0x20
        instr = 32'h400040B3; mem_ready = 1'b1; #1;
        nxt;
        chk("ill_dec", {29'd0, state}, 32'd1);
        nxt;
        chk("ill_trap", {28'd0, state, illegal}, {28'd0, 3'd5, 1'b1});
        chk("ill_strb", {29'd0, reg_write, mem_read, pc_write}, 32'd0);
        nxt; nxt;
        chk("ill_sticky", {28'd0, state, illegal}, {28'd0, 3'd5, 1'b1});
        rst = 1'b1;
        nxt;
        rst = 1'b0; #1;
        chk("ill_cleared", {28'd0, state, illegal}, {28'd0, 3'd0, 1'b0});

        // FETCH timeout: 16 wait cycles then TRAP
        mem_ready = 1'b0; instr = 32'h002081B3; #1;
        for (int i = 0; i < 16; i++) begin
            nxt;
            chk("tmo_wait", {29'd0, state}, 32'd0);
        end
        nxt;
        chk("tmo_trap", {28'd0, state, illegal}, {28'd0, 3'd5, 1'b1});
        mem_ready = 1'b1; #1;
        chk("tmo_no_strb", {30'd0, mem_read, ir_write}, 32'd0);
        nxt;
        chk("tmo_sticky", {28'd0, state, illegal}, {28'd0, 3'd5, 1'b1});
        rst = 1'b1;
        nxt; nxt;
        chk("tmo_rst_illegal", {31'd0, illegal}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
